// File: rtl/string_hw_master.sv
`default_nettype none
// ============================================================================
// Module      : string_hw_master
// Description : Avalon-MM master that sequences a string-accelerator job.
//               It streams the A and B strings into the accelerator register
//               map, starts the job, polls for completion, then reads the
//               result words back out on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module string_hw_master #(
  parameter int MAX_BLOCKS   = 8,
  parameter int ADDRESS_BITS = 5,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  // job command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_index,
  input  logic [7:0]              cmd_length,
  // string word stream (A words then B words)
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  // result word stream
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  // Avalon-MM master
  output logic [ADDRESS_BITS-1:0] avm_address,
  output logic                    avm_chipselect,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  input  logic [31:0]             avm_readdata,
  input  logic                    avm_waitrequest,
  // status
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int KW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [KW-1:0] K_LAST = KW'(MAX_BLOCKS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(POLL_LIMIT);

  localparam logic [ADDRESS_BITS-1:0] ADDR_CTRL = '0;
  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE  = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS-1:0] ADDR_BOFS = ADDRESS_BITS'(MAX_BLOCKS + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_A    = 4'd1;
  localparam logic [3:0] S_LOAD_B    = 4'd2;
  localparam logic [3:0] S_GO        = 4'd3;
  localparam logic [3:0] S_POLL      = 4'd4;
  localparam logic [3:0] S_POLL_WAIT = 4'd5;
  localparam logic [3:0] S_RES_RD    = 4'd6;
  localparam logic [3:0] S_RES_WAIT  = 4'd7;
  localparam logic [3:0] S_RES_OUT   = 4'd8;
  localparam logic [3:0] S_CLR       = 4'd9;

  logic [3:0]              state_q,     state_d;
  logic [KW-1:0]           k_q,         k_d;
  logic [PW-1:0]           poll_q,      poll_d;
  logic [3:0]              index_q,     index_d;
  logic [7:0]              length_q,    length_d;
  logic                    rd_q,        rd_d;
  logic                    wr_q,        wr_d;
  logic [ADDRESS_BITS-1:0] addr_q,      addr_d;
  logic [31:0]             wdata_q,     wdata_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             out_data_q,  out_data_d;
  logic                    err_q,       err_d;

  // Derived helper values used by the next-state logic.
  logic [KW-1:0]           w_k_next;
  logic [PW-1:0]           w_poll_inc;
  logic [ADDRESS_BITS-1:0] w_addr_k;
  logic [31:0]             w_ctrl_go;

  assign w_k_next   = (k_q == K_LAST) ? '0 : k_q + KW'(1);
  assign w_poll_inc = poll_q + PW'(1);
  assign w_addr_k   = ADDRESS_BITS'(k_q) + ADDR_ONE;
  assign w_ctrl_go  = {18'b0, length_q, index_q, 1'b1, 1'b0};

  // State register: every flop, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      poll_q      <= '0;
      index_q     <= '0;
      length_q    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      poll_q      <= poll_d;
      index_q     <= index_d;
      length_q    <= length_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: each bus-issuing state raises its strobe when idle and
  // holds it (with address/data) until the slave drops waitrequest.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    poll_d      = poll_q;
    index_d     = index_q;
    length_d    = length_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          index_d  = cmd_index;
          length_d = cmd_length;
          k_d      = '0;
          poll_d   = '0;
          state_d  = S_LOAD_A;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (wr_q) begin
          if (!avm_waitrequest) begin
            wr_d = 1'b0;
            k_d  = w_k_next;
            if (k_q == K_LAST) begin
              state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_GO;
            end
          end
        end else if (in_valid) begin
          wr_d    = 1'b1;
          addr_d  = (state_q == S_LOAD_A) ? w_addr_k
                                          : ADDRESS_BITS'(k_q) + ADDR_BOFS;
          wdata_d = in_data;
        end
      end

      S_GO: begin
        if (wr_q) begin
          if (!avm_waitrequest) begin
            wr_d    = 1'b0;
            state_d = S_POLL;
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = w_ctrl_go;
        end
      end

      S_POLL: begin
        if (rd_q) begin
          if (!avm_waitrequest) begin
            rd_d    = 1'b0;
            state_d = S_POLL_WAIT;
          end
        end else begin
          rd_d    = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = '0;
        end
      end

      // Read data is valid exactly one cycle after the accepting cycle.
      S_POLL_WAIT: begin
        if (avm_readdata[0]) begin
          k_d     = '0;
          state_d = S_RES_RD;
        end else begin
          poll_d = w_poll_inc;
          if (w_poll_inc == P_LAST) begin
            err_d   = 1'b1;
            state_d = S_CLR;
          end else begin
            state_d = S_POLL;
          end
        end
      end

      S_RES_RD: begin
        if (rd_q) begin
          if (!avm_waitrequest) begin
            rd_d    = 1'b0;
            state_d = S_RES_WAIT;
          end
        end else begin
          rd_d    = 1'b1;
          addr_d  = w_addr_k;
          wdata_d = '0;
        end
      end

      S_RES_WAIT: begin
        out_data_d  = avm_readdata;
        out_valid_d = 1'b1;
        state_d     = S_RES_OUT;
      end

      // No further reads are issued until the current word is taken.
      S_RES_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          k_d         = w_k_next;
          state_d     = (k_q == K_LAST) ? S_CLR : S_RES_RD;
        end
      end

      S_CLR: begin
        if (wr_q) begin
          if (!avm_waitrequest) begin
            wr_d    = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: handshake readies decode the state, bus and stream
  // outputs come straight from flops.
  always_comb begin
    cmd_ready      = (state_q == S_IDLE);
    in_ready       = ((state_q == S_LOAD_A) || (state_q == S_LOAD_B)) && !wr_q;
    busy           = (state_q != S_IDLE);
    err_timeout    = err_q;
    out_valid      = out_valid_q;
    out_data       = out_data_q;
    avm_address    = addr_q;
    avm_read       = rd_q;
    avm_write      = wr_q;
    avm_chipselect = rd_q | wr_q;
    avm_writedata  = wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_string_hw_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_string_hw_master
// Description : Scoreboard bench for string_hw_master. Stimulus pushes the
//               expected bus transfers and result words; monitors pop and
//               compare whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_string_hw_master;

  localparam int N          = 8;
  localparam int DONE_AFTER = 5;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  cmd_index;
  logic [7:0]  cmd_length;
  logic [31:0] in_data;

  // main instance (default POLL_LIMIT)
  logic        cmd_valid_m, cmd_ready_m, in_valid_m, in_ready_m;
  logic        out_valid_m, out_ready_m;
  logic [31:0] out_data_m;
  logic [4:0]  addr_m;
  logic        cs_m, rd_m, wr_m, wait_m, busy_m, err_m;
  logic [31:0] wdata_m, rdata_m;

  // timeout instance (POLL_LIMIT = 4, done never set)
  logic        cmd_valid_t, cmd_ready_t, in_valid_t, in_ready_t;
  logic        out_valid_t, out_ready_t;
  logic [31:0] out_data_t;
  logic [4:0]  addr_t;
  logic        cs_t, rd_t, wr_t, wait_t, busy_t, err_t;
  logic [31:0] wdata_t, rdata_t;

  assign out_ready_t = 1'b1;
  assign wait_t      = 1'b0;
  assign rdata_t     = 32'h0;

  string_hw_master u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_m), .cmd_ready(cmd_ready_m),
    .cmd_index(cmd_index), .cmd_length(cmd_length),
    .in_valid(in_valid_m), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready_m), .out_data(out_data_m),
    .avm_address(addr_m), .avm_chipselect(cs_m), .avm_read(rd_m),
    .avm_write(wr_m), .avm_writedata(wdata_m), .avm_readdata(rdata_m),
    .avm_waitrequest(wait_m), .busy(busy_m), .err_timeout(err_m)
  );

  string_hw_master #(.POLL_LIMIT(4)) u_to (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
    .cmd_index(cmd_index), .cmd_length(cmd_length),
    .in_valid(in_valid_t), .in_ready(in_ready_t), .in_data(in_data),
    .out_valid(out_valid_t), .out_ready(out_ready_t), .out_data(out_data_t),
    .avm_address(addr_t), .avm_chipselect(cs_t), .avm_read(rd_t),
    .avm_write(wr_t), .avm_writedata(wdata_t), .avm_readdata(rdata_t),
    .avm_waitrequest(wait_t), .busy(busy_t), .err_timeout(err_t)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bus_t        exp_bus[$];
  bus_t        exp_bus2[$];
  logic [31:0] exp_out[$];

  int waits   = 0;
  int bp_word = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic bad(input string name, input int v);
    n_tests++;
    n_fail++;
    $display("FAIL %s: observed %0d, required event did not occur as expected", name, v);
  endtask

  // Slave model for the main instance: programmable wait states, status
  // register reports done after DONE_AFTER polls, result i = 0xC0DE0000+i.
  int wcnt  = 0;
  int polls = 0;
  assign wait_m = (rd_m | wr_m) && (wcnt < waits);

  always @(posedge clk) begin
    if (reset) begin
      wcnt    <= 0;
      rdata_m <= 32'h0;
    end else if ((rd_m | wr_m) && wait_m) begin
      wcnt <= wcnt + 1;
    end else if (rd_m | wr_m) begin
      wcnt <= 0;
      if (wr_m && addr_m == 5'd0 && wdata_m[1]) polls <= 0;
      if (rd_m) begin
        if (addr_m == 5'd0) begin
          rdata_m <= (polls >= DONE_AFTER) ? 32'h1 : 32'h0;
          polls   <= polls + 1;
        end else begin
          rdata_m <= 32'hC0DE0000 + 32'(addr_m) - 32'd1;
        end
      end
    end
  end

  // Monitor for the main instance: bus transfers, hold stability,
  // result stream and read suppression while a result is pending.
  logic        pend_m = 1'b0;
  logic [4:0]  paddr_m;
  logic [31:0] pdata_m;
  int          hold_m = 0;
  int          acc_m  = 0;
  int          out_cnt = 0;
  int          stall_seen = 0;
  logic        ov_prev = 1'b0, or_prev = 1'b0;
  logic [31:0] od_prev = 32'h0;

  always @(negedge clk) begin
    bus_t        e;
    logic [31:0] w;
    if (!reset && (rd_m | wr_m)) begin
      if (pend_m) begin
        chk("hold_addr", addr_m, paddr_m);
        chk("hold_wdata", wdata_m, pdata_m);
        hold_m++;
      end else begin
        hold_m = 1;
      end
      paddr_m = addr_m;
      pdata_m = wdata_m;
      pend_m  = 1'b1;
      if (!wait_m) begin
        pend_m = 1'b0;
        acc_m++;
        chk("chipselect", cs_m, 1);
        chk("rd_wr_exclusive", rd_m & wr_m, 0);
        chk("hold_cycles", hold_m, waits + 1);
        if (exp_bus.size() == 0) begin
          bad("bus_unexpected_addr", addr_m);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_kind_wr", wr_m, e.wr);
          chk("bus_addr", addr_m, e.addr);
          if (e.wr) chk("bus_wdata", wdata_m, e.data);
        end
      end
    end else begin
      pend_m = 1'b0;
    end

    if (out_valid_m) chk("no_read_while_out_valid", rd_m, 0);
    if (out_valid_m && ov_prev && !or_prev) chk("out_data_hold", out_data_m, od_prev);
    if (out_valid_m && !out_ready_m) stall_seen++;
    if (out_valid_m && out_ready_m) begin
      out_cnt++;
      if (exp_out.size() == 0) begin
        bad("out_unexpected_word", out_cnt);
      end else begin
        w = exp_out.pop_front();
        chk("out_data", out_data_m, w);
      end
    end
    ov_prev = out_valid_m & ~reset;
    or_prev = out_ready_m;
    od_prev = out_data_m;
  end

  // Result consumer: stalls out_ready for 10 cycles on word bp_word.
  initial begin
    int low_cnt;
    low_cnt     = 0;
    out_ready_m = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid_m && out_cnt == bp_word && low_cnt < 10) begin
        out_ready_m = 1'b0;
        low_cnt++;
      end else begin
        out_ready_m = 1'b1;
        if (out_cnt != bp_word) low_cnt = 0;
      end
    end
  end

  // Monitor for the timeout instance.
  int err_hi_t = 0;
  int ov_t_cnt = 0;
  always @(negedge clk) begin
    bus_t e;
    if (!reset && (rd_t | wr_t)) begin
      if (exp_bus2.size() == 0) begin
        bad("to_bus_unexpected_addr", addr_t);
      end else begin
        e = exp_bus2.pop_front();
        chk("to_bus_kind_wr", wr_t, e.wr);
        chk("to_bus_addr", addr_t, e.addr);
        if (e.wr) chk("to_bus_wdata", wdata_t, e.data);
      end
    end
    if (err_t) err_hi_t++;
    if (out_valid_t) ov_t_cnt++;
  end

  task automatic push_bus(input int sel, input bit wr, input int addr, input logic [31:0] d);
    bus_t e;
    e.wr   = wr;
    e.addr = addr[4:0];
    e.data = d;
    if (sel == 0) exp_bus.push_back(e);
    else          exp_bus2.push_back(e);
  endtask

  task automatic send_cmd(input int sel, input logic [3:0] idx, input logic [7:0] len);
    int   b;
    logic hs;
    cmd_index  = idx;
    cmd_length = len;
    if (sel == 0) cmd_valid_m = 1'b1;
    else          cmd_valid_t = 1'b1;
    b  = 0;
    hs = 1'b0;
    while (!hs && b < 200) begin
      @(negedge clk);
      hs = (sel == 0) ? cmd_ready_m : cmd_ready_t;
      @(posedge clk);
      #1;
      b++;
    end
    cmd_valid_m = 1'b0;
    cmd_valid_t = 1'b0;
    if (!hs) bad("cmd_handshake_timeout", b);
  endtask

  task automatic send_word(input int sel, input logic [31:0] d);
    int   b;
    logic hs;
    in_data = d;
    if (sel == 0) in_valid_m = 1'b1;
    else          in_valid_t = 1'b1;
    b  = 0;
    hs = 1'b0;
    while (!hs && b < 200) begin
      @(negedge clk);
      hs = (sel == 0) ? in_ready_m : in_ready_t;
      @(posedge clk);
      #1;
      b++;
    end
    in_valid_m = 1'b0;
    in_valid_t = 1'b0;
    if (!hs) bad("in_handshake_timeout", b);
  endtask

  task automatic wait_done(input int sel);
    int   b;
    logic done;
    b    = 0;
    done = 1'b0;
    while (!done && b < 5000) begin
      @(negedge clk);
      b++;
      if (sel == 0) done = !busy_m && exp_bus.size() == 0 && exp_out.size() == 0;
      else          done = !busy_t && exp_bus2.size() == 0;
    end
    if (!done) bad("job_completion_timeout", b);
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input int sel);
    for (int i = 0; i < N; i++) push_bus(sel, 1'b1, i + 1, 32'h41000000 + 32'(i));
    for (int i = 0; i < N; i++) push_bus(sel, 1'b1, N + 1 + i, 32'h42000000 + 32'(i));
    push_bus(sel, 1'b1, 0, 32'h0000040E);
  endtask

  task automatic send_strings(input int sel);
    for (int i = 0; i < N; i++) send_word(sel, 32'h41000000 + 32'(i));
    for (int i = 0; i < N; i++) send_word(sel, 32'h42000000 + 32'(i));
  endtask

  task automatic run_nominal(input int w, input int bpw);
    waits   = w;
    bp_word = (bpw < 0) ? -1 : out_cnt + bpw;
    push_load(0);
    for (int i = 0; i < 6; i++) push_bus(0, 1'b0, 0, 32'h0);
    for (int i = 0; i < N; i++) push_bus(0, 1'b0, i + 1, 32'h0);
    push_bus(0, 1'b1, 0, 32'h0);
    for (int i = 0; i < N; i++) exp_out.push_back(32'hC0DE0000 + 32'(i));
    send_cmd(0, 4'd3, 8'd16);
    send_strings(0);
    wait_done(0);
    chk("busy_after_job", busy_m, 0);
    chk("cmd_ready_after_job", cmd_ready_m, 1);
    bp_word = -1;
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_ready", cmd_ready_m, 1);
    chk("rst_in_ready", in_ready_m, 0);
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_avm_read", rd_m, 0);
    chk("rst_avm_write", wr_m, 0);
    chk("rst_avm_chipselect", cs_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_err_timeout", err_m, 0);
    chk("rst_avm_address", addr_m, 0);
    chk("rst_avm_writedata", wdata_m, 0);
    chk("rst_out_data", out_data_m, 0);
  endtask

  initial begin
    int s0, a0, b;
    reset       = 1'b1;
    cmd_valid_m = 1'b0;
    cmd_valid_t = 1'b0;
    in_valid_m  = 1'b0;
    in_valid_t  = 1'b0;
    cmd_index   = 4'd0;
    cmd_length  = 8'd0;
    in_data     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // nominal
    run_nominal(0, -1);

    // waitrequest: 3 wait cycles per transfer
    run_nominal(3, -1);

    // backpressure on result word 2
    s0 = stall_seen;
    run_nominal(0, 2);
    chk("bp_stall_cycles", stall_seen - s0, 10);

    // timeout on the POLL_LIMIT=4 instance
    push_load(1);
    for (int i = 0; i < 4; i++) push_bus(1, 1'b0, 0, 32'h0);
    push_bus(1, 1'b1, 0, 32'h0);
    send_cmd(1, 4'd3, 8'd16);
    send_strings(1);
    wait_done(1);
    chk("to_err_pulse_cycles", err_hi_t, 1);
    chk("to_no_out_valid", ov_t_cnt, 0);
    chk("to_busy_after", busy_t, 0);
    chk("to_cmd_ready_after", cmd_ready_t, 1);

    // reset mid-load after 5 A words
    waits = 0;
    for (int i = 0; i < 5; i++) push_bus(0, 1'b1, i + 1, 32'h41000000 + 32'(i));
    a0 = acc_m;
    send_cmd(0, 4'd3, 8'd16);
    for (int i = 0; i < 5; i++) send_word(0, 32'h41000000 + 32'(i));
    b = 0;
    while (acc_m < a0 + 5 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (acc_m < a0 + 5) bad("midload_write_timeout", acc_m - a0);
    @(posedge clk);
    #1;
    chk("midload_busy_before_reset", busy_m, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    chk("midload_bus_queue_drained", exp_bus.size(), 0);
    run_nominal(0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/string_hw_master.md
STRING_HW_MASTER -- requirements
Module: string_hw_master

Interface
REQ-001 The block SHALL have parameter MAX_BLOCKS, default 8, meaning the number of 32-bit words per string and per result.
REQ-002 The block SHALL have parameter ADDRESS_BITS, default 5, meaning the width of the Avalon master address.
REQ-003 The block SHALL have parameter POLL_LIMIT, default 1024, meaning the maximum number of status reads before timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_index (input, 4) and cmd_length (input, 8): the job command handshake.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32): the string word stream, carrying A0..A[N-1] then B0..B[N-1].
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 32): the result word stream.
REQ-009 The block SHALL have ports avm_address (output, ADDRESS_BITS), avm_chipselect, avm_read and avm_write (outputs, 1 each), avm_writedata (output, 32), avm_readdata (input, 32) and avm_waitrequest (input, 1): the Avalon-MM master connected to the accelerator register map.
REQ-010 The block SHALL have ports busy (output, 1), high while not IDLE, and err_timeout (output, 1), a one-cycle pulse on timeout.

Function
REQ-011 The accelerator register map SHALL be used as follows.
- Address 0: control/status word {length[13:6], index[5:2], go[1], done[0]}.
- Addresses 1..N: A words on write; result words on read while done=1.
- Addresses N+1..2N: B words.
- N = MAX_BLOCKS.
REQ-012 A bus write or read SHALL be accepted in the cycle its strobe is high and avm_waitrequest is low; strobes, address and writedata SHALL be held stable until accepted.
REQ-013 Read data SHALL be sampled from avm_readdata exactly one cycle after the accepting cycle (fixed read latency 1).
REQ-014 avm_chipselect SHALL equal avm_read OR avm_write; avm_read and avm_write SHALL never be high together.
REQ-015 The block SHALL implement states IDLE, LOAD_A, LOAD_B, GO, POLL, POLL_WAIT, RES_RD, RES_WAIT, RES_OUT, CLR.
REQ-016 IDLE: cmd_ready=1. When cmd_valid is high, the block SHALL latch cmd_index and cmd_length, clear the word counter k and the poll counter, and go to LOAD_A.
REQ-017 LOAD_A/LOAD_B: in_ready SHALL be high only while no write is pending.
- Each accepted in_data word SHALL be written to address k+1 (LOAD_A) or N+k+1 (LOAD_B).
- k SHALL increment on write acceptance and wrap from N-1 to 0, advancing LOAD_A to LOAD_B and LOAD_B to GO.
REQ-018 GO: the block SHALL write address 0 with data {18'b0, length, index, 1'b1, 1'b0}, then go to POLL.
REQ-019 POLL: the block SHALL read address 0 and go to POLL_WAIT. In POLL_WAIT:
- If the sampled bit0=1, clear k and go to RES_RD.
- Else increment the poll counter; when it reaches POLL_LIMIT, pulse err_timeout and go to CLR; otherwise return to POLL.
REQ-020 RES_RD: the block SHALL read address k+1, then go to RES_WAIT. RES_WAIT SHALL capture the read data into out_data, set out_valid, and go to RES_OUT.
REQ-021 RES_OUT: out_valid and out_data SHALL be held until out_ready is high. On handshake:
- Clear out_valid and increment k.
- Go to CLR after word N-1; otherwise return to RES_RD.
REQ-022 CLR: the block SHALL write address 0 with data 0 (go=0), then return to IDLE.
REQ-023 Timeout jobs SHALL emit no result words.
REQ-024 cmd_valid and in_valid SHALL be ignored in states where their ready signal is low.
REQ-025 At most one bus transaction SHALL be outstanding at any time; no bus read SHALL be issued while out_valid is high.

Reset
REQ-026 On reset the block SHALL enter IDLE and set k=0 and poll counter=0.
REQ-027 On reset all outputs SHALL take these values: cmd_ready=1; in_ready, out_valid, avm_read, avm_write, avm_chipselect, busy and err_timeout=0; avm_address, avm_writedata and out_data=0.
REQ-028 Reset asserted mid-job SHALL abort immediately, with no further bus strobes, even if a transaction is pending under waitrequest.

Verification
REQ-029 Scenario "nominal": N=8, index=3, length=16, strings Ai=0x41000000+i and Bi=0x42000000+i, slave asserts done after 5 polls.
- Expected: 16 data writes to addresses 1..16 in order.
- Expected: control write 0x0000040E.
- Expected: 6 reads of address 0, then 8 result reads of addresses 1..8 emitted in order on out_*.
- Expected: a final write of 0 to address 0, then busy falls.
REQ-030 Scenario "waitrequest": waitrequest high for 3 cycles on every transfer -> each strobe is held 4 cycles, address/data stay stable, and the transfer sequence is identical to REQ-029.
REQ-031 Scenario "backpressure": out_ready low for 10 cycles on result word 2 -> out_data holds word 2 and no read of address 4 is issued until the handshake.
REQ-032 Scenario "timeout": POLL_LIMIT=4 and done never set -> exactly 4 status reads, a single err_timeout pulse, a write of 0 to address 0, no out_valid, and a return to IDLE.
REQ-033 Scenario "reset mid-load": reset asserted after 5 A-words -> the next cycle shows all REQ-027 values, and a new command restarts at address 1.
